cond_flag_checker: RTL and testbench

- Self-checking stimulus driver for the opposite end of the vector-to-flag reduction (`result = data ? 1 : 0`).
- Sweeps a WIDTH-bit `data` bus through every value and waits a programmable settle time per value.
- Samples the DUT's 1-bit `result` and compares it with the expected value, `expected = (data != 0)`.
- Counts mismatches, captures the first failing vector, and reports done/pass. Used as the on-chip driver/checker for conditional-reduction paths, e.g. CPU flag logic.

---
 rtl/cond_flag_checker.sv | 126 ++++++++++++
 tb/tb_cond_flag_checker.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/cond_flag_checker.sv
// Stimulus driver and checker for a "result = (data != 0)" reduction path.
// Sweeps data through every value, samples result after a settle time, and tallies mismatches.
module cond_flag_checker #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1,
  parameter int PASSES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] data,
  input  logic             result,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_data
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PW = 10;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [PW-1:0] PASS_LAST   = PW'(PASSES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [PW-1:0]    pass_q, pass_d;
  logic [7:0]       err_q, err_d;
  logic             fev_q, fev_d;
  logic [WIDTH-1:0] fed_q, fed_d;

  logic settle_last, data_last, pass_last, mismatch;

  assign settle_last = (settle_q == SETTLE_LAST);
  assign data_last   = (data_q == {WIDTH{1'b1}});
  assign pass_last   = (pass_q == PASS_LAST);
  // Case inequality so an X/Z on result is flagged rather than silently matching.
  assign mismatch    = (result !== (data_q != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_WAIT;
      S_WAIT:         if (settle_last) state_d = S_CHECK;
      S_CHECK:        state_d = (data_last && pass_last) ? S_DONE : S_WAIT;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_WAIT) || (state_q == S_CHECK);
    done = (state_q == S_DONE);
    pass = done && (err_q == 8'd0);
  end

  always_comb begin
    data_d   = data_q;
    settle_d = settle_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fev_d    = fev_q;
    fed_d    = fed_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          data_d   = '0;
          settle_d = '0;
          pass_d   = '0;
          err_d    = 8'd0;
          fev_d    = 1'b0;
        end
      end
      S_WAIT: settle_d = settle_last ? '0 : settle_q + 1'b1;
      S_CHECK: begin
        if (mismatch) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          if (!fev_q) begin
            fev_d = 1'b1;
            fed_d = data_q;
          end
        end
        // data stays at all-ones after the final vector so DONE shows the last value.
        if (!data_last) begin
          data_d = data_q + 1'b1;
        end else if (!pass_last) begin
          pass_d = pass_q + 1'b1;
          data_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      settle_q <= '0;
      pass_q   <= '0;
      err_q    <= 8'd0;
      fev_q    <= 1'b0;
      fed_q    <= '0;
    end else begin
      data_q   <= data_d;
      settle_q <= settle_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fev_q    <= fev_d;
      fed_q    <= fed_d;
    end
  end

  assign data            = data_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_data  = fed_q;

endmodule

// File: tb/tb_cond_flag_checker.sv
// Directed, table-driven bench for cond_flag_checker: a short sweep instance and a 300-pass instance.
module tb_cond_flag_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start_b;
  logic [1:0] data, data_b;
  logic       result, result_b;
  logic       busy, busy_b, done, done_b, pass, pass_b;
  logic [7:0] err_count, err_count_b;
  logic       fev, fev_b;
  logic [1:0] fed, fed_b;
  int         mode;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cond_flag_checker #(.WIDTH(2), .SETTLE(1), .PASSES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data(data), .result(result),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_valid(fev), .first_err_data(fed)
  );

  cond_flag_checker #(.WIDTH(2), .SETTLE(1), .PASSES(300)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .data(data_b), .result(result_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_count_b),
    .first_err_valid(fev_b), .first_err_data(fed_b)
  );

  // mode 0: correct reduction, 1: stuck at 0, 2: stuck at 1
  always_comb begin
    case (mode)
      0:       result = |data;
      1:       result = 1'b0;
      default: result = 1'b1;
    endcase
  end
  assign result_b = 1'b0;

  typedef struct {
    int mode;
    int glitch;
    int exp_err;
    int exp_fev;
    int exp_fed;
    int exp_pass;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_row(input vec_t v);
    int cyc;
    mode = v.mode;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_done", done, 0);
    chk("accept_err", err_count, 0);
    chk("accept_fev", fev, 0);
    cyc = 0;
    while (!done && cyc < 50) begin
      chk("data_seq", data, cyc / 2);
      start = (v.glitch != 0 && cyc == v.glitch);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_cycle", cyc, 8);
    chk("done", done, 1);
    chk("busy_end", busy, 0);
    chk("err_count", err_count, v.exp_err);
    chk("first_err_valid", fev, v.exp_fev);
    if (v.exp_fev != 0) chk("first_err_data", fed, v.exp_fed);
    chk("pass", pass, v.exp_pass);
    chk("data_final", data, 3);
    repeat (3) @(negedge clk);
    chk("done_hold", done, 1);
    chk("err_hold", err_count, v.exp_err);
    chk("pass_hold", pass, v.exp_pass);
  endtask

  vec_t rows[5];

  initial begin
    int cyc;
    rows[0] = '{mode: 0, glitch: 0, exp_err: 0, exp_fev: 0, exp_fed: 0, exp_pass: 1};
    rows[1] = '{mode: 1, glitch: 0, exp_err: 3, exp_fev: 1, exp_fed: 1, exp_pass: 0};
    rows[2] = '{mode: 2, glitch: 0, exp_err: 1, exp_fev: 1, exp_fed: 0, exp_pass: 0};
    rows[3] = '{mode: 0, glitch: 3, exp_err: 0, exp_fev: 0, exp_fed: 0, exp_pass: 1};
    rows[4] = '{mode: 1, glitch: 5, exp_err: 3, exp_fev: 1, exp_fed: 1, exp_pass: 0};

    mode    = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    start_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_fev", fev, 0);
    chk("rst_fed", fed, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 5; i++) run_row(rows[i]);

    // Reset during vector 2's WAIT, with a start pulse held under reset.
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_data", data, 2);
    rst_n = 1'b0;
    #1;
    chk("mrst_data", data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_err", err_count, 0);
    chk("mrst_done", done, 0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    run_row(rows[0]);

    // Long run: error counter must saturate.
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    cyc = 0;
    while (!done_b && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("sat_done_cycle", cyc, 2400);
    chk("sat_done", done_b, 1);
    chk("sat_err", err_count_b, 255);
    chk("sat_fev", fev_b, 1);
    chk("sat_fed", fed_b, 1);
    chk("sat_pass", pass_b, 0);
    chk("sat_data", data_b, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
